// File: rtl/code_check_pkg.sv
// Shared types and helpers for the keypad code checker family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package code_check_pkg;

  // Checker FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    PROG     = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // Total width of a stored code: all digits packed, first digit in the MSBs.
  function automatic int code_w(input int num_digits, input int digit_w);
    return num_digits * digit_w;
  endfunction

endpackage

// File: rtl/code_check_n_rise_detect.sv
// Rising-edge detector for a level keypad input; one pulse per 0->1 transition.
// Latency: pulse is combinational from the input, qualified by the previous-cycle sample.
// Backpressure: none; an input held high produces exactly one pulse.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Remember last cycle's level so only a fresh rise is reported.
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/code_check_n.sv
// Keypad code checker: collects digits, verifies against a reprogrammable code, locks out after repeated failures.
// Latency: unlock or fail is registered one cycle after the edge that captures the last digit.
// Backpressure: none; digit strobes arriving in CHECK or LOCKOUT are dropped.
module code_check_n
  import code_check_pkg::*;
#(
  parameter int                            DIGIT_W        = 2,
  parameter int                            NUM_DIGITS     = 3,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE   = 6'b01_01_11,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            LOCKOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [DIGIT_W-1:0]    digit,
  input  logic                  enter,
  output logic [NUM_DIGITS-1:0] led_progress,
  output logic                  unlock,
  output logic                  clk_enb,
  output logic                  fail,
  output logic                  locked_out
);

  localparam int CODE_W = code_w(NUM_DIGITS, DIGIT_W);
  localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int CNT_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [TRY_W-1:0]    tries;
  logic [CNT_W-1:0]    cnt;
  logic [CODE_W-1:0]   code_reg;
  logic [CODE_W-1:0]   buf_q;
  logic [CODE_W-1:0]   buf_next;
  logic [NUM_DIGITS-1:0] led_next;
  logic [TRY_W-1:0]    tries_inc;
  logic                epulse;

  rise_detect u_enter_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (enter),
    .pulse (epulse)
  );

  // Buffer and LED image with the current digit dropped into slot idx.
  always_comb begin
    buf_next = buf_q;
    led_next = led_progress;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        buf_next[CODE_W-1-i*DIGIT_W -: DIGIT_W] = digit;
        led_next[i] = 1'b1;
      end
    end
  end

  // Failure count after one more miss, held at the ceiling.
  assign tries_inc = (tries == TRY_MAX) ? tries : tries + TRY_W'(1);

  // Checker FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      tries        <= '0;
      cnt          <= '0;
      code_reg     <= DEFAULT_CODE;
      buf_q        <= '0;
      led_progress <= '0;
      unlock       <= 1'b0;
      clk_enb      <= 1'b0;
      fail         <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (epulse) begin
            buf_q        <= buf_next;
            led_progress <= led_next;
            idx          <= idx + IDX_W'(1);
            if (idx == IDX_LAST) state <= CHECK;
          end
        end

        CHECK: begin
          idx          <= '0;
          led_progress <= '0;
          if (buf_q == code_reg) begin
            state   <= UNLOCKED;
            unlock  <= 1'b1;
            clk_enb <= 1'b1;
            tries   <= '0;
          end else begin
            fail  <= 1'b1;
            tries <= tries_inc;
            if (tries_inc == TRY_MAX) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
              cnt        <= CNT_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        UNLOCKED: begin
          if (epulse) begin
            if (!mode) begin
              // Relock: the strobing digit is discarded.
              state   <= IDLE;
              unlock  <= 1'b0;
              clk_enb <= 1'b0;
            end else if (idx == IDX_LAST) begin
              // Single-digit codes finish programming on the first digit.
              code_reg     <= buf_next;
              state        <= IDLE;
              unlock       <= 1'b0;
              clk_enb      <= 1'b0;
              led_progress <= '0;
              idx          <= '0;
            end else begin
              buf_q        <= buf_next;
              led_progress <= led_next;
              idx          <= idx + IDX_W'(1);
              state        <= PROG;
            end
          end
        end

        PROG: begin
          if (epulse) begin
            if (idx == IDX_LAST) begin
              // Commit includes the digit arriving on this very edge.
              code_reg     <= buf_next;
              buf_q        <= buf_next;
              state        <= IDLE;
              unlock       <= 1'b0;
              clk_enb      <= 1'b0;
              led_progress <= '0;
              idx          <= '0;
            end else begin
              buf_q        <= buf_next;
              led_progress <= led_next;
              idx          <= idx + IDX_W'(1);
            end
          end
        end

        LOCKOUT: begin
          if (cnt == '0) begin
            state      <= IDLE;
            tries      <= '0;
            locked_out <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_check_n.sv
// Self-checking bench for code_check_n against a transaction-level lock model.
// Latency: outputs sampled on falling edges, inputs driven on falling edges.
// Backpressure: n/a.
module tb_code_check_n;

  localparam int DW = 2;
  localparam int ND = 3;
  localparam int CW = ND * DW;
  localparam int MT = 3;
  localparam int LC = 8;
  localparam logic [CW-1:0]    DEF      = 6'b01_01_11;
  localparam logic [ND*ND-1:0] LEDS_SEQ = 9'b111_011_001;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [DW-1:0] digit;
  logic          enter;
  logic [ND-1:0] led_progress;
  logic          unlock, clk_enb, fail, locked_out;

  int checks = 0;
  int errors = 0;

  // Lock model: stored code, consecutive failure count, unlocked flag.
  logic [CW-1:0] m_code;
  int            m_tries;
  bit            m_unlocked;

  typedef struct packed {
    logic [ND*ND-1:0] leds;
    logic             unl_e;
    logic             fail_e;
    logic             unl_e1;
    logic             enb_e1;
    logic             fail_e1;
    logic             lo_e1;
    logic [ND-1:0]    led_e1;
  } obs_t;

  code_check_n #(
    .DIGIT_W(DW), .NUM_DIGITS(ND), .DEFAULT_CODE(DEF),
    .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .digit(digit), .enter(enter),
    .led_progress(led_progress), .unlock(unlock), .clk_enb(clk_enb),
    .fail(fail), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dig(input logic [CW-1:0] c, input int i);
    return c[CW-1-i*DW -: DW];
  endfunction

  // {unlock, clk_enb, fail, locked_out} one cycle after the last digit.
  function automatic logic [3:0] exp_vec(input int outcome);
    case (outcome)
      1:       return 4'b1100;
      2:       return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic model_reset();
    m_code = DEF; m_tries = 0; m_unlocked = 0;
  endtask

  // Outcome of a verify attempt: 0 wrong, 1 unlocked, 2 wrong and lockout.
  task automatic model_attempt(input logic [CW-1:0] c, output int outcome);
    if (c == m_code) begin
      m_tries = 0; m_unlocked = 1; outcome = 1;
    end else begin
      m_tries++;
      if (m_tries >= MT) begin m_tries = 0; outcome = 2; end
      else outcome = 0;
    end
  endtask

  task automatic press(input logic [DW-1:0] d);
    @(negedge clk);
    digit = d; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0; digit = DW'($urandom());
  endtask

  task automatic submit(input logic [CW-1:0] c, output obs_t o);
    o = '0;
    for (int i = 0; i < ND; i++) begin
      press(dig(c, i));
      o.leds[i*ND +: ND] = led_progress;
    end
    o.unl_e = unlock; o.fail_e = fail;
    @(negedge clk);
    o.unl_e1 = unlock; o.enb_e1 = clk_enb; o.fail_e1 = fail;
    o.lo_e1 = locked_out; o.led_e1 = led_progress;
  endtask

  // Counts cycles locked_out stays high while hammering random keys.
  task automatic measure_lockout(output int n);
    n = 0;
    while (locked_out === 1'b1 && n < 100) begin
      n++;
      digit = DW'($urandom()); enter = 1'($urandom()); mode = 1'($urandom());
      @(negedge clk);
    end
    enter = 1'b0; mode = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [CW-1:0] wrong_code();
    logic [CW-1:0] c;
    do c = CW'($urandom()); while (c == m_code);
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; enter = 1'b0; mode = 1'b0; digit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({led_progress, unlock, clk_enb, fail, locked_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {led_progress, unlock, clk_enb, fail, locked_out});
    end
  endtask

  task automatic test_unlock();
    obs_t o; int oc;
    submit(DEF, o); model_attempt(DEF, oc);
    checks++;
    if (o.leds !== LEDS_SEQ) begin errors++; $display("FAIL unlock_leds: got %b want %b", o.leds, LEDS_SEQ); end
    checks++;
    if ({o.unl_e, o.fail_e} !== 2'b00) begin errors++; $display("FAIL unlock_early: got %b want 00", {o.unl_e, o.fail_e}); end
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
      errors++; $display("FAIL unlock_result: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
    end
    checks++;
    if (o.led_e1 !== '0) begin errors++; $display("FAIL unlock_leds_clear: got %b want 000", o.led_e1); end
    mode = 1'b0; press(DW'($urandom())); m_unlocked = 0;
    checks++;
    if ({unlock, clk_enb, led_progress} !== '0) begin
      errors++; $display("FAIL relock: got %b want 0", {unlock, clk_enb, led_progress});
    end
  endtask

  task automatic test_wrong();
    obs_t o; int oc; logic [CW-1:0] c;
    c = wrong_code();
    submit(c, o); model_attempt(c, oc);
    checks++;
    if (o.leds !== LEDS_SEQ) begin errors++; $display("FAIL wrong_leds: got %b want %b", o.leds, LEDS_SEQ); end
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1, o.led_e1} !== {exp_vec(oc), 3'b000}) begin
      errors++; $display("FAIL wrong_result: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1, o.led_e1}, {exp_vec(oc), 3'b000});
    end
    @(negedge clk);
    checks++;
    if ({fail, unlock} !== 2'b00) begin errors++; $display("FAIL wrong_fail_width: got %b want 00", {fail, unlock}); end
  endtask

  task automatic test_lockout();
    obs_t o; int oc; int n; logic [CW-1:0] c;
    oc = 0;
    for (int k = 0; k < MT && oc != 2; k++) begin
      c = wrong_code();
      submit(c, o); model_attempt(c, oc);
      checks++;
      if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
        errors++; $display("FAIL lockout_attempt%0d: got %b want %b", k, {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
      end
    end
    measure_lockout(n);
    checks++;
    if (n != LC) begin errors++; $display("FAIL lockout_length: got %0d want %0d", n, LC); end
    @(negedge clk);
    checks++;
    if ({led_progress, unlock} !== '0) begin errors++; $display("FAIL lockout_keys_ignored: got %b want 0", {led_progress, unlock}); end
    submit(m_code, o); model_attempt(m_code, oc);
    checks++;
    if ({o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== {LEDS_SEQ, exp_vec(oc)}) begin
      errors++; $display("FAIL lockout_then_unlock: got %b want %b", {o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, {LEDS_SEQ, exp_vec(oc)});
    end
    mode = 1'b0; press(DW'($urandom())); m_unlocked = 0;
  endtask

  task automatic test_program();
    obs_t o; int oc; logic [CW-1:0] nc;
    nc = 6'b10_00_11;
    submit(m_code, o); model_attempt(m_code, oc);
    checks++;
    if (o.unl_e1 !== 1'b1) begin errors++; $display("FAIL prog_preunlock: got %b want 1", o.unl_e1); end
    mode = 1'b1; press(dig(nc, 0));
    checks++;
    if ({led_progress, unlock, clk_enb} !== 5'b001_11) begin errors++; $display("FAIL prog_digit0: got %b want 00111", {led_progress, unlock, clk_enb}); end
    mode = 1'b0; press(dig(nc, 1));
    checks++;
    if ({led_progress, unlock} !== 4'b011_1) begin errors++; $display("FAIL prog_digit1: got %b want 0111", {led_progress, unlock}); end
    press(dig(nc, 2));
    m_code = nc; m_unlocked = 0;
    checks++;
    if ({led_progress, unlock, clk_enb} !== '0) begin errors++; $display("FAIL prog_commit: got %b want 0", {led_progress, unlock, clk_enb}); end
    submit(DEF, o); model_attempt(DEF, oc);
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
      errors++; $display("FAIL prog_old_code: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
    end
    submit(nc, o); model_attempt(nc, oc);
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
      errors++; $display("FAIL prog_new_code: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
    end
    mode = 1'b0; press(DW'($urandom())); m_unlocked = 0;
  endtask

  task automatic test_hold();
    obs_t o; int oc;
    @(negedge clk);
    digit = 2'b01; enter = 1'b1;
    repeat (20) begin
      @(negedge clk);
      digit = DW'($urandom()); mode = 1'($urandom());
    end
    checks++;
    if (led_progress !== 3'b001) begin errors++; $display("FAIL hold_one_digit: got %b want 001", led_progress); end
    enter = 1'b0; mode = 1'b0;
    press(DW'($urandom()));
    checks++;
    if (led_progress !== 3'b011) begin errors++; $display("FAIL hold_second_digit: got %b want 011", led_progress); end
    pulse_reset();
    checks++;
    if ({led_progress, unlock} !== '0) begin errors++; $display("FAIL reset_mid_entry: got %b want 0", {led_progress, unlock}); end
    submit(DEF, o); model_attempt(DEF, oc);
    checks++;
    if ({o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== {LEDS_SEQ, exp_vec(oc)}) begin
      errors++; $display("FAIL reset_restart_entry: got %b want %b", {o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, {LEDS_SEQ, exp_vec(oc)});
    end
    mode = 1'b0; press(DW'($urandom())); m_unlocked = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o; int oc; logic [CW-1:0] c;
    oc = 0;
    for (int k = 0; k < MT && oc != 2; k++) begin
      c = wrong_code(); submit(c, o); model_attempt(c, oc);
    end
    checks++;
    if (locked_out !== 1'b1) begin errors++; $display("FAIL rst_lock_entered: got %b want 1", locked_out); end
    repeat (3) @(negedge clk);
    pulse_reset();
    checks++;
    if ({locked_out, fail, unlock} !== 3'b000) begin errors++; $display("FAIL rst_in_lockout: got %b want 000", {locked_out, fail, unlock}); end
    // Two misses after reset must not lock out if tries restarted at zero.
    for (int k = 0; k < MT - 1; k++) begin
      c = wrong_code(); submit(c, o); model_attempt(c, oc);
      checks++;
      if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
        errors++; $display("FAIL rst_tries_cleared%0d: got %b want %b", k, {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
      end
    end
    submit(DEF, o); model_attempt(DEF, oc);
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
      errors++; $display("FAIL rst_default_code: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
    end
    mode = 1'b1;
    c = 6'b11_10_00;
    for (int i = 0; i < ND; i++) press(dig(c, i));
    mode = 1'b0;
    pulse_reset();
    submit(DEF, o); model_attempt(DEF, oc);
    checks++;
    if ({o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== exp_vec(oc)) begin
      errors++; $display("FAIL rst_after_prog: got %b want %b", {o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, exp_vec(oc));
    end
    mode = 1'b0; press(DW'($urandom())); m_unlocked = 0;
  endtask

  task automatic test_random();
    obs_t o; int oc; int n; logic [CW-1:0] c;
    for (int it = 0; it < 40; it++) begin
      if (m_unlocked) begin
        if ($urandom_range(1, 0) == 0) begin
          mode = 1'b0; press(DW'($urandom()));
        end else begin
          c = CW'($urandom());
          mode = 1'b1;
          for (int i = 0; i < ND; i++) begin
            press(dig(c, i));
            mode = 1'($urandom());
          end
          mode = 1'b0;
          m_code = c;
        end
        m_unlocked = 0;
        checks++;
        if ({unlock, clk_enb, led_progress} !== '0) begin
          errors++; $display("FAIL rand_relock%0d: got %b want 0", it, {unlock, clk_enb, led_progress});
        end
      end else begin
        c = ($urandom_range(2, 0) == 0) ? m_code : CW'($urandom());
        submit(c, o); model_attempt(c, oc);
        checks++;
        if ({o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1} !== {LEDS_SEQ, exp_vec(oc)}) begin
          errors++; $display("FAIL rand_attempt%0d: got %b want %b", it, {o.leds, o.unl_e1, o.enb_e1, o.fail_e1, o.lo_e1}, {LEDS_SEQ, exp_vec(oc)});
        end
        if (oc == 2) begin
          measure_lockout(n);
          checks++;
          if (n != LC) begin errors++; $display("FAIL rand_lockout%0d: got %0d want %0d", it, n, LC); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong();
    test_lockout();
    test_program();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
